p_to_s: RTL and testbench



---
 rtl/p_to_s.sv | 113 +++++++++++
 tb/tb_p_to_s.sv | 377 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/p_to_s.sv
// Parallel-to-serial converter: WIDTH-bit words in over valid/ready, one bit
// per transfer out with a last-bit marker, plus a one-word holding buffer.
module p_to_s #(
    parameter int WIDTH     = 6,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_a,
    output logic             ready_a,
    input  logic [WIDTH-1:0] data_a,
    output logic             valid_b,
    input  logic             ready_b,
    output logic             data_b,
    output logic             last_b
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    // State encoding is {busy, hold_full}; {0,1} cannot occur.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b10,
        FULL  = 2'b11
    } state_t;

    state_t             state;
    logic [WIDTH-1:0]   shifter;
    logic [WIDTH-1:0]   hold;
    logic [CNT_W-1:0]   cnt;

    logic               busy;
    logic               hold_full;
    logic               accept;
    logic               xfer;
    logic               final_xfer;
    logic               out_bit;
    logic [WIDTH-1:0]   shifted;

    assign busy       = (state != IDLE);
    assign hold_full  = (state == FULL);

    assign ready_a    = !hold_full && !rst;
    assign accept     = valid_a && ready_a;

    // Outputs are forced quiet during the reset cycle even if a word was mid-flight.
    assign valid_b    = busy && !rst;
    assign xfer       = valid_b && ready_b;
    assign final_xfer = xfer && (cnt == LAST_CNT);

    assign out_bit    = MSB_FIRST ? shifter[WIDTH-1] : shifter[0];
    assign data_b     = valid_b && out_bit;
    assign last_b     = valid_b && (cnt == LAST_CNT);

    assign shifted    = MSB_FIRST ? {shifter[WIDTH-2:0], 1'b0}
                                  : {1'b0, shifter[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shifter <= '0;
            hold    <= '0;
            cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        shifter <= data_a;
                        cnt     <= '0;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (final_xfer) begin
                        // A word accepted on the final-bit edge goes straight in, keeping output gap-free.
                        if (accept) begin
                            shifter <= data_a;
                        end else begin
                            shifter <= '0;
                            state   <= IDLE;
                        end
                        cnt <= '0;
                    end else begin
                        if (xfer) begin
                            shifter <= shifted;
                            cnt     <= cnt + CNT_W'(1);
                        end
                        if (accept) begin
                            hold  <= data_a;
                            state <= FULL;
                        end
                    end
                end
                FULL: begin
                    if (final_xfer) begin
                        shifter <= hold;
                        hold    <= '0;
                        cnt     <= '0;
                        state   <= SHIFT;
                    end else if (xfer) begin
                        shifter <= shifted;
                        cnt     <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_p_to_s.sv
// Self-checking bench for p_to_s: default 6-bit MSB-first instance plus an
// 8-bit LSB-first instance, checked against a scoreboard of expected bits.
module tb_p_to_s;

    typedef struct packed {
        logic d;
        logic l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_a = 1'b0;
    logic       ready_a;
    logic [5:0] data_a = '0;
    logic       valid_b;
    logic       ready_b = 1'b0;
    logic       data_b;
    logic       last_b;

    logic       valid_a_8 = 1'b0;
    logic       ready_a_8;
    logic [7:0] data_a_8 = '0;
    logic       valid_b_8;
    logic       ready_b_8 = 1'b0;
    logic       data_b_8;
    logic       last_b_8;

    int   total = 0;
    int   bad = 0;
    exp_t q[$];
    exp_t q8[$];
    exp_t e;
    bit   ok;
    bit   acc;
    bit   xf;
    logic o_ready_a, o_valid_b, o_data_b, o_last_b;

    p_to_s dut (
        .clk(clk), .rst(rst),
        .valid_a(valid_a), .ready_a(ready_a), .data_a(data_a),
        .valid_b(valid_b), .ready_b(ready_b), .data_b(data_b), .last_b(last_b)
    );

    p_to_s #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
        .clk(clk), .rst(rst),
        .valid_a(valid_a_8), .ready_a(ready_a_8), .data_a(data_a_8),
        .valid_b(valid_b_8), .ready_b(ready_b_8), .data_b(data_b_8), .last_b(last_b_8)
    );

    always #5 clk = ~clk;

    // One cycle on the 6-bit instance: drive at negedge, sample 1ns later, queue accepted words.
    task automatic tick(input bit r, input bit va, input logic [5:0] da, input bit rb);
        exp_t ne;
        @(negedge clk);
        rst = r; valid_a = va; data_a = da; ready_b = rb;
        #1;
        o_ready_a = ready_a; o_valid_b = valid_b; o_data_b = data_b; o_last_b = last_b;
        acc = va && o_ready_a;
        xf  = o_valid_b && rb;
        if (acc) begin
            for (int i = 0; i < 6; i++) begin
                ne.d = da[5-i];
                ne.l = (i == 5);
                q.push_back(ne);
            end
        end
    endtask

    task automatic pop_exp(output bit found, output exp_t pe);
        found = (q.size() != 0);
        pe = '0;
        if (found) pe = q.pop_front();
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b1, 6'h3F, 1'b1);
        total++;
        if ({o_ready_a, o_valid_b, o_data_b, o_last_b} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_hold: rdy/vld/dat/last=%b%b%b%b expected 0000",
                     o_ready_a, o_valid_b, o_data_b, o_last_b);
        end
        total++;
        if ({ready_a_8, valid_b_8, data_b_8, last_b_8} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_hold_w8: rdy/vld/dat/last=%b%b%b%b expected 0000",
                     ready_a_8, valid_b_8, data_b_8, last_b_8);
        end
        q.delete();
        tick(1'b0, 1'b0, 6'h00, 1'b1);
        total++;
        if ({o_ready_a, o_valid_b, o_data_b, o_last_b} !== 4'b1000) begin
            bad++;
            $display("[TB] FAIL reset_release: rdy/vld/dat/last=%b%b%b%b expected 1000",
                     o_ready_a, o_valid_b, o_data_b, o_last_b);
        end
    endtask

    task automatic test_single_word();
        int n = 0, first = -1, lastx = -1;
        tick(1'b0, 1'b1, 6'b101100, 1'b1);
        total++;
        if (acc !== 1'b1) begin
            bad++;
            $display("[TB] FAIL single_accept: accepted=%b expected 1", acc);
        end
        for (int i = 1; i <= 12; i++) begin
            tick(1'b0, 1'b0, 6'h00, 1'b1);
            if (xf) begin
                pop_exp(ok, e);
                total++;
                if (!ok || {o_data_b, o_last_b} !== {e.d, e.l}) begin
                    bad++;
                    $display("[TB] FAIL single_bit: cycle %0d data/last=%b%b expected %b%b queued=%0b",
                             i, o_data_b, o_last_b, e.d, e.l, ok);
                end
                if (first < 0) first = i;
                lastx = i;
                n++;
            end else begin
                total++;
                if ({o_data_b, o_last_b} !== 2'b00) begin
                    bad++;
                    $display("[TB] FAIL single_idle_out: data/last=%b%b expected 00", o_data_b, o_last_b);
                end
            end
        end
        total++;
        if (n != 6 || first != 1 || lastx != 6) begin
            bad++;
            $display("[TB] FAIL single_timing: bits=%0d first=%0d last=%0d expected 6/1/6", n, first, lastx);
        end
        total++;
        if ({o_valid_b, o_ready_a} !== 2'b01 || q.size() != 0) begin
            bad++;
            $display("[TB] FAIL single_idle: vld/rdy=%b%b left=%0d expected 01 with 0 left",
                     o_valid_b, o_ready_a, q.size());
        end
    endtask

    task automatic test_backpressure();
        int n = 0, lastx = -1;
        bit rb;
        tick(1'b0, 1'b1, 6'b101100, 1'b1);
        for (int i = 1; i <= 14; i++) begin
            rb = !(i >= 2 && i <= 4);
            tick(1'b0, 1'b0, 6'h00, rb);
            if (o_valid_b && !rb) begin
                total++;
                // Bit 2 of 101100 is 0 and not last.
                if ({o_data_b, o_last_b} !== 2'b00 || q.size() == 0 || q[0] !== exp_t'(2'b00)) begin
                    bad++;
                    $display("[TB] FAIL stall_hold: cycle %0d data/last=%b%b expected 00", i, o_data_b, o_last_b);
                end
            end
            if (xf) begin
                pop_exp(ok, e);
                total++;
                if (!ok || {o_data_b, o_last_b} !== {e.d, e.l}) begin
                    bad++;
                    $display("[TB] FAIL stall_bit: cycle %0d data/last=%b%b expected %b%b", i,
                             o_data_b, o_last_b, e.d, e.l);
                end
                lastx = i;
                n++;
            end
        end
        total++;
        if (n != 6 || lastx != 9) begin
            bad++;
            $display("[TB] FAIL stall_duration: bits=%0d final_cycle=%0d expected 6/9", n, lastx);
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] words [2] = '{6'b111000, 6'b010101};
        int k = 0;
        bit va;
        for (int i = 0; i <= 13; i++) begin
            va = (k < 2);
            tick(1'b0, va, va ? words[k] : 6'h00, 1'b1);
            if (acc) k++;
            if (i >= 1 && i <= 12) begin
                total++;
                if (o_valid_b !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL b2b_gap: cycle %0d valid=%b expected 1", i, o_valid_b);
                end
            end
            if (i >= 2 && i <= 6) begin
                total++;
                if (o_ready_a !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL b2b_full_ready: cycle %0d ready=%b expected 0", i, o_ready_a);
                end
            end
            if (i == 7 || i == 13) begin
                total++;
                if (o_ready_a !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL b2b_ready_back: cycle %0d ready=%b expected 1", i, o_ready_a);
                end
            end
            if (xf) begin
                pop_exp(ok, e);
                total++;
                if (!ok || {o_data_b, o_last_b} !== {e.d, e.l}) begin
                    bad++;
                    $display("[TB] FAIL b2b_bit: cycle %0d data/last=%b%b expected %b%b", i,
                             o_data_b, o_last_b, e.d, e.l);
                end
            end
        end
        total++;
        if (k != 2 || q.size() != 0 || o_valid_b !== 1'b0) begin
            bad++;
            $display("[TB] FAIL b2b_done: accepted=%0d left=%0d valid=%b expected 2/0/0", k, q.size(), o_valid_b);
        end
    endtask

    task automatic test_full_stall();
        logic [5:0] words [3] = '{6'b100110, 6'b011001, 6'b111100};
        int acc_at [3] = '{-5, -5, -5};
        int k = 0, fin_a = -1;
        bit va;
        for (int i = 0; i < 30; i++) begin
            va = (k < 3);
            tick(1'b0, va, va ? words[k] : 6'h00, i >= 4);
            if (i >= 2 && fin_a < 0) begin
                total++;
                if (o_ready_a !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL full_ready: cycle %0d ready=%b expected 0", i, o_ready_a);
                end
            end
            if (acc) begin
                acc_at[k] = i;
                k++;
            end
            if (xf) begin
                pop_exp(ok, e);
                total++;
                if (!ok || {o_data_b, o_last_b} !== {e.d, e.l}) begin
                    bad++;
                    $display("[TB] FAIL full_bit: cycle %0d data/last=%b%b expected %b%b", i,
                             o_data_b, o_last_b, e.d, e.l);
                end
                if (ok && e.l && fin_a < 0) fin_a = i;
            end
        end
        total++;
        if (acc_at[0] != 0 || acc_at[1] != 1 || fin_a < 0 || acc_at[2] != fin_a + 1) begin
            bad++;
            $display("[TB] FAIL full_accept_times: got %0d,%0d,%0d expected 0,1,%0d",
                     acc_at[0], acc_at[1], acc_at[2], fin_a + 1);
        end
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("[TB] FAIL full_drain: left=%0d expected 0", q.size());
        end
    endtask

    task automatic test_reset_mid_word();
        int n = 0;
        tick(1'b0, 1'b1, 6'b110011, 1'b1);
        tick(1'b0, 1'b1, 6'b101010, 1'b1);
        for (int i = 0; i < 3; i++) begin
            if (xf) begin
                pop_exp(ok, e);
                total++;
                if (!ok || {o_data_b, o_last_b} !== {e.d, e.l}) begin
                    bad++;
                    $display("[TB] FAIL rstmid_pre_bit: data/last=%b%b expected %b%b", o_data_b, o_last_b, e.d, e.l);
                end
            end
            if (i < 2) tick(1'b0, 1'b0, 6'h00, 1'b1);
        end
        tick(1'b1, 1'b1, 6'b000111, 1'b1);
        total++;
        if ({o_ready_a, o_valid_b, o_data_b, o_last_b} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL rstmid_during: rdy/vld/dat/last=%b%b%b%b expected 0000",
                     o_ready_a, o_valid_b, o_data_b, o_last_b);
        end
        q.delete();
        tick(1'b0, 1'b0, 6'h00, 1'b1);
        total++;
        if ({o_ready_a, o_valid_b, o_data_b} !== 3'b100) begin
            bad++;
            $display("[TB] FAIL rstmid_after: rdy/vld/dat=%b%b%b expected 100", o_ready_a, o_valid_b, o_data_b);
        end
        tick(1'b0, 1'b1, 6'b110011, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            tick(1'b0, 1'b0, 6'h00, 1'b1);
            if (xf) begin
                pop_exp(ok, e);
                total++;
                if (!ok || {o_data_b, o_last_b} !== {e.d, e.l}) begin
                    bad++;
                    $display("[TB] FAIL rstmid_fresh_bit: cycle %0d data/last=%b%b expected %b%b queued=%0b",
                             i, o_data_b, o_last_b, e.d, e.l, ok);
                end
                n++;
            end
        end
        total++;
        if (n != 6 || q.size() != 0) begin
            bad++;
            $display("[TB] FAIL rstmid_fresh_count: bits=%0d left=%0d expected 6/0", n, q.size());
        end
    endtask

    task automatic test_width8_lsb_first();
        logic [7:0] seq = 8'b1010_0101;
        exp_t ne;
        int n = 0;
        @(negedge clk);
        valid_a_8 = 1'b1; data_a_8 = 8'hA5; ready_b_8 = 1'b1;
        #1;
        total++;
        if (ready_a_8 !== 1'b1) begin
            bad++;
            $display("[TB] FAIL w8_accept: ready=%b expected 1", ready_a_8);
        end
        for (int i = 0; i < 8; i++) begin
            ne.d = seq[7-i];
            ne.l = (i == 7);
            q8.push_back(ne);
        end
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            valid_a_8 = 1'b0;
            #1;
            if (valid_b_8) begin
                total++;
                if (q8.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL w8_bit: cycle %0d extra bit data=%b", i, data_b_8);
                end else begin
                    ne = q8.pop_front();
                    if ({data_b_8, last_b_8} !== {ne.d, ne.l}) begin
                        bad++;
                        $display("[TB] FAIL w8_bit: cycle %0d data/last=%b%b expected %b%b",
                                 i, data_b_8, last_b_8, ne.d, ne.l);
                    end
                end
                n++;
            end
        end
        total++;
        if (n != 8 || q8.size() != 0) begin
            bad++;
            $display("[TB] FAIL w8_count: bits=%0d left=%0d expected 8/0", n, q8.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_backpressure();
        test_back_to_back();
        test_full_stall();
        test_reset_mid_word();
        test_width8_lsb_first();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
